// File: rtl/mem_arbiter.sv
// mem_arbiter: CPU/DMA round-robin arbiter onto a byte-wide memory.
// A granted transfer runs IDLE -> LO [-> HI] -> FIN -> IDLE; memory read data
// arrives one cycle after its address, so each byte is captured on the
// following state's edge. Ack and rdata appear together in the cycle after FIN.
// Optional feature: define MEMARB_WORD_EN to enable 16-bit (two-byte) transfers.
module mem_arbiter (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        c_req,
    input  logic        c_we,
    input  logic        c_word,
    input  logic [19:0] c_addr,
    input  logic [15:0] c_wdata,
    output logic        c_ack,
    output logic [15:0] c_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_word,
    input  logic [19:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    output logic [19:0] address,
    output logic [7:0]  out,
    output logic        wren,
    input  logic [7:0]  data
);

`ifdef MEMARB_WORD_EN
    typedef enum logic [1:0] {IDLE, LO, HI, FIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, LO, FIN} state_t;
`endif

    state_t      state;
    logic        last_dma;   // 1: DMA was granted most recently
    logic        gnt_dma;    // owner of the transfer in flight
    logic        we_q;
    logic        c_go, d_go, pick_dma, sel_we;
    logic [19:0] sel_addr;
    logic [7:0]  sel_wlo;
    logic [15:0] rd_val;

`ifdef MEMARB_WORD_EN
    logic        word_q, sel_word;
    logic [19:0] addr_q;
    logic [7:0]  wdata_hi_q, sel_whi, lo_byte;
`else
    // Byte-only build: word flags and upper write bytes have no effect.
    logic unused_word;
    assign unused_word = c_word ^ d_word ^ (^c_wdata[15:8]) ^ (^d_wdata[15:8]);
`endif

    // Grant selection and read-data assembly.
    always_comb begin
        // A port still holding req during its own ack cycle is finishing,
        // not asking again, so it is masked for that one IDLE sample.
        c_go     = c_req & ~c_ack;
        d_go     = d_req & ~d_ack;
        pick_dma = d_go & (~c_go | ~last_dma);
        sel_we   = pick_dma ? d_we         : c_we;
        sel_addr = pick_dma ? d_addr       : c_addr;
        sel_wlo  = pick_dma ? d_wdata[7:0] : c_wdata[7:0];
        rd_val   = {8'h00, data};
`ifdef MEMARB_WORD_EN
        sel_word = pick_dma ? d_word        : c_word;
        sel_whi  = pick_dma ? d_wdata[15:8] : c_wdata[15:8];
        if (word_q) rd_val = {data, lo_byte};
`endif
    end

    // Transfer FSM with registered memory-side and port-side outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            wren     <= 1'b0;
            address  <= 20'h0;
            out      <= 8'h0;
            c_ack    <= 1'b0;
            d_ack    <= 1'b0;
            c_rdata  <= 16'h0;
            d_rdata  <= 16'h0;
            last_dma <= 1'b1;
            gnt_dma  <= 1'b0;
            we_q     <= 1'b0;
`ifdef MEMARB_WORD_EN
            word_q     <= 1'b0;
            addr_q     <= 20'h0;
            wdata_hi_q <= 8'h0;
            lo_byte    <= 8'h0;
`endif
        end else begin
            c_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    wren <= 1'b0;
                    if (c_go || d_go) begin
                        gnt_dma  <= pick_dma;
                        last_dma <= pick_dma;
                        we_q     <= sel_we;
                        address  <= sel_addr;
                        out      <= sel_wlo;
                        wren     <= sel_we;
`ifdef MEMARB_WORD_EN
                        word_q     <= sel_word;
                        addr_q     <= sel_addr;
                        wdata_hi_q <= sel_whi;
`endif
                        state    <= LO;
                    end
                end
                LO: begin
`ifdef MEMARB_WORD_EN
                    if (word_q) begin
                        address <= addr_q + 20'd1;   // wraps 0xFFFFF -> 0x00000
                        out     <= wdata_hi_q;
                        wren    <= we_q;
                        state   <= HI;
                    end else begin
                        wren  <= 1'b0;
                        state <= FIN;
                    end
`else
                    wren  <= 1'b0;
                    state <= FIN;
`endif
                end
`ifdef MEMARB_WORD_EN
                HI: begin
                    lo_byte <= data;                 // response to the LO address
                    wren    <= 1'b0;
                    state   <= FIN;
                end
`endif
                FIN: begin
                    wren <= 1'b0;
                    if (!we_q) begin
                        if (gnt_dma) d_rdata <= rd_val;
                        else         c_rdata <= rd_val;
                    end
                    if (gnt_dma) d_ack <= 1'b1;
                    else         c_ack <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    wren  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed + random transfers against a transaction-level
// model (round-robin order, latency per transfer size, byte memory image).
module tb_mem_arbiter;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        c_req, c_we, c_word, c_ack;
    logic [19:0] c_addr;
    logic [15:0] c_wdata, c_rdata;
    logic        d_req, d_we, d_word, d_ack;
    logic [19:0] d_addr;
    logic [15:0] d_wdata, d_rdata;
    logic [19:0] address;
    logic [7:0]  out;
    logic        wren;
    logic [7:0]  data = 8'h00;

`ifdef MEMARB_WORD_EN
    localparam bit WORD_EN = 1'b1;
`else
    localparam bit WORD_EN = 1'b0;
`endif

    int          checks = 0;
    int          errors = 0;
    int          last_p;                 // 0 CPU, 1 DMA granted most recently
    logic [15:0] exp_rd [2];
    logic        f_we [2];
    logic        f_word [2];
    logic [19:0] f_addr [2];
    logic [15:0] f_wdata [2];
    logic [7:0]  phys [0:1048575];       // memory the DUT talks to
    logic [7:0]  refm [0:1048575];       // memory image the model expects

    always #5 clock = ~clock;

    mem_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .c_req(c_req), .c_we(c_we), .c_word(c_word), .c_addr(c_addr),
        .c_wdata(c_wdata), .c_ack(c_ack), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_word(d_word), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .address(address), .out(out), .wren(wren), .data(data)
    );

    // Synchronous memory: read data one cycle after the address.
    always @(posedge clock) begin
        data <= phys[address];
        if (wren) phys[address] <= out;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_port(input int p, input logic we, input logic word,
                            input logic [19:0] a, input logic [15:0] w);
        f_we[p] = we; f_word[p] = word; f_addr[p] = a; f_wdata[p] = w;
        if (p == 0) begin c_we = we; c_word = word; c_addr = a; c_wdata = w; end
        else        begin d_we = we; d_word = word; d_addr = a; d_wdata = w; end
    endtask

    // Effect of a completed transfer on the model memory / expected rdata.
    task automatic apply(input int p);
        logic [19:0] a, a1;
        logic        ew;
        a  = f_addr[p];
        a1 = a + 20'd1;
        ew = f_word[p] & WORD_EN;
        if (f_we[p]) begin
            refm[a] = f_wdata[p][7:0];
            if (ew) refm[a1] = f_wdata[p][15:8];
            chk("mem_lo", 32'(phys[a]), 32'(refm[a]));
            if (ew) chk("mem_hi", 32'(phys[a1]), 32'(refm[a1]));
        end else begin
            exp_rd[p] = ew ? {refm[a1], refm[a]} : {8'h00, refm[a]};
        end
    endtask

    // Run one arbitration episode. d_delay>0 raises d_req that many cycles in.
    task automatic xfer(input bit use_c, input bit use_d, input int d_delay, input string tag);
        int   first, second, last_a;
        int   lat [2];
        int   g [2];
        int   a [2];
        bit   act [2];
        bit   drop [2];
        bit   ew, exp_ack;
        logic obs_ack;
        lat[0] = (f_word[0] & WORD_EN) ? 3 : 2;
        lat[1] = (f_word[1] & WORD_EN) ? 3 : 2;
        g = '{0, 0}; a = '{0, 0}; drop = '{0, 0};
        act[0] = use_c; act[1] = use_d;
        second = -1;
        if (use_c && use_d) begin
            first  = (d_delay > 0 || last_p == 1) ? 0 : 1;
            second = 1 - first;
        end else first = use_c ? 0 : 1;
        g[first] = 1; a[first] = 1 + lat[first]; last_a = a[first]; last_p = first;
        if (second >= 0) begin
            g[second] = a[first] + 1; a[second] = g[second] + lat[second];
            last_a = a[second]; last_p = second;
        end
        c_req = use_c;
        d_req = use_d && (d_delay == 0);
        for (int cyc = 1; cyc <= last_a; cyc++) begin
            @(posedge clock); #1;
            if (drop[0]) begin c_req = 1'b0; drop[0] = 1'b0; end
            if (drop[1]) begin d_req = 1'b0; drop[1] = 1'b0; end
            chk({tag, "_ack_excl"}, 32'(c_ack & d_ack), 32'd0);
            for (int p = 0; p < 2; p++) if (act[p]) begin
                ew = f_word[p] & WORD_EN;
                if (cyc == g[p]) begin
                    chk({tag, "_lo_addr"}, 32'(address), 32'(f_addr[p]));
                    chk({tag, "_lo_out"},  32'(out),     32'(f_wdata[p][7:0]));
                    chk({tag, "_lo_wren"}, 32'(wren),    32'(f_we[p]));
                end
                if (ew && cyc == g[p] + 1) begin
                    chk({tag, "_hi_addr"}, 32'(address), 32'(f_addr[p] + 20'd1));
                    chk({tag, "_hi_out"},  32'(out),     32'(f_wdata[p][15:8]));
                    chk({tag, "_hi_wren"}, 32'(wren),    32'(f_we[p]));
                end
                if (cyc == a[p] - 1) chk({tag, "_fin_wren"}, 32'(wren), 32'd0);
            end
            for (int p = 0; p < 2; p++) begin
                obs_ack = (p == 0) ? c_ack : d_ack;
                exp_ack = act[p] && (cyc == a[p]);
                chk({tag, (p == 0) ? "_c_ack" : "_d_ack"}, 32'(obs_ack), 32'(exp_ack));
                if (exp_ack) begin
                    apply(p);
                    chk({tag, "_c_rdata"}, 32'(c_rdata), 32'(exp_rd[0]));
                    chk({tag, "_d_rdata"}, 32'(d_rdata), 32'(exp_rd[1]));
                    drop[p] = 1'b1;
                end
            end
            if (use_d && d_delay > 0 && cyc == d_delay) d_req = 1'b1;
        end
        @(posedge clock); #1;
        c_req = 1'b0; d_req = 1'b0;
        chk({tag, "_post_ack"},  32'({c_ack, d_ack}), 32'd0);
        chk({tag, "_post_wren"}, 32'(wren), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_wren"},    32'(wren),    32'd0);
        chk({tag, "_address"}, 32'(address), 32'd0);
        chk({tag, "_out"},     32'(out),     32'd0);
        chk({tag, "_acks"},    32'({c_ack, d_ack}), 32'd0);
        chk({tag, "_c_rdata"}, 32'(c_rdata), 32'd0);
        chk({tag, "_d_rdata"}, 32'(d_rdata), 32'd0);
    endtask

    function automatic logic [19:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 20'hFFFFF;
        if (r == 1) return 20'h00000;
        return 20'h00400 + 20'($urandom_range(0, 7));
    endfunction

    initial begin
        logic [19:0] ra;
        logic [15:0] rw;
        int          mode;
        for (int i = 0; i < 1048576; i++) begin
            phys[i] = 8'($urandom);
            refm[i] = phys[i];
        end
        reset_n = 1'b0;
        c_req = 1'b0; d_req = 1'b0;
        set_port(0, 1'b0, 1'b0, 20'h0, 16'h0);
        set_port(1, 1'b0, 1'b0, 20'h0, 16'h0);

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check_reset_state("reset");
        last_p = 1; exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
        reset_n = 1'b1;

        // Both ports requesting byte reads: CPU, DMA, CPU, DMA
        set_port(0, 1'b0, 1'b0, 20'h00100, 16'h0);
        set_port(1, 1'b0, 1'b0, 20'h00200, 16'h0);
        xfer(1, 1, 0, "rr1");
        set_port(0, 1'b0, 1'b0, 20'h00101, 16'h0);
        set_port(1, 1'b0, 1'b0, 20'h00201, 16'h0);
        xfer(1, 1, 0, "rr2");

        // CPU byte read of 0xA5 at 0x12345
        phys[20'h12345] = 8'hA5; refm[20'h12345] = 8'hA5;
        set_port(0, 1'b0, 1'b0, 20'h12345, 16'h0);
        xfer(1, 0, 0, "cpu_rd");
        chk("cpu_rd_value", 32'(c_rdata), 32'h00A5);

        // DMA word write at the top of memory, high byte wraps to 0
        set_port(1, 1'b1, 1'b1, 20'hFFFFF, 16'hBEEF);
        xfer(0, 1, 0, "dma_wr");
        chk("dma_wr_lo_mem", 32'(phys[20'hFFFFF]), 32'h00EF);
        if (WORD_EN) chk("dma_wr_hi_mem", 32'(phys[0]), 32'h00BE);

        // DMA request arrives mid CPU word transfer
        set_port(0, 1'b0, 1'b1, 20'h00300, 16'h0);
        set_port(1, 1'b0, 1'b0, 20'h00304, 16'h0);
        xfer(1, 1, 2, "late_d");

        // Word flag on CPU read at 0x10
        phys[20'h00010] = 8'h77; refm[20'h00010] = 8'h77;
        set_port(0, 1'b0, 1'b1, 20'h00010, 16'h0);
        xfer(1, 0, 0, "cpu_w_rd");
        if (!WORD_EN) chk("cpu_w_rd_value", 32'(c_rdata), 32'h0077);

        // Reset in the last write cycle of a CPU write (HI for word builds)
        set_port(0, 1'b1, 1'b1, 20'h00500, 16'h5AC3);
        c_req = 1'b1;
        @(posedge clock); #1;
        if (WORD_EN) begin @(posedge clock); #1; end
        chk("abort_wren_before", 32'(wren), 32'd1);
        reset_n = 1'b0; c_req = 1'b0;
        @(posedge clock); #1;
        check_reset_state("abort");
        refm[20'h00500] = 8'hC3;
        if (WORD_EN) refm[20'h00501] = 8'h5A;
        last_p = 1; exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            chk("abort_no_ack", 32'({c_ack, d_ack}), 32'd0);
        end
        set_port(0, 1'b0, 1'b1, 20'h00500, 16'h0);
        xfer(1, 0, 0, "after_abort");

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            for (int p = 0; p < 2; p++) begin
                ra = rand_addr();
                rw = 16'($urandom);
                set_port(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rw);
            end
            mode = int'($urandom_range(0, 2));
            if (mode == 0)      xfer(1, 0, 0, "rnd_c");
            else if (mode == 1) xfer(0, 1, 0, "rnd_d");
            else                xfer(1, 1, 0, "rnd_cd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clock  in  1  sole clock; all state updates on rising edge.
REQ-002 reset_n  in  1  reset, synchronous, active-low.
REQ-003 c_req, c_we, c_word  in  1 each  CPU port: request, write, 16-bit transfer.
REQ-004 c_addr  in  20; c_wdata  in  16  CPU byte address; write data, low byte at c_addr.
REQ-005 c_ack  out  1; c_rdata  out  16  CPU one-cycle completion pulse; read data.
REQ-006 d_req, d_we, d_word, d_addr, d_wdata, d_ack, d_rdata  same directions and widths  DMA/video port.
REQ-007 address  out  20; out  out  8; wren  out  1  byte-wide memory address, write data, write enable.
REQ-008 data  in  8  memory read data, valid one cycle after its address is driven.

Function
REQ-009 States: IDLE, LO, HI, FIN; exactly one active.
REQ-010 IDLE: sample c_req/d_req; if none, stay IDLE with wren=0.
REQ-011 Only one requesting: grant it; both requesting: grant the port not granted last (round-robin).
REQ-012 On grant, latch the winner's we, word, addr and wdata; go to LO.
REQ-013 LO: address=addr, out=wdata[7:0], wren=we; go to HI if word, else FIN.
REQ-014 HI: address=(addr+1) mod 2^20, so 0xFFFFF wraps to 0x00000; out=wdata[15:8]; wren=we; capture data into rdata[7:0].
REQ-015 FIN: wren=0; capture data into rdata[15:8] (word) or rdata[7:0] with rdata[15:8]=0 (byte); pulse the granted port's ack for one cycle; go to IDLE.
REQ-016 Rdata is updated only for the granted port and only on reads; writes leave rdata unchanged.
REQ-017 Latency from the IDLE grant edge to the ack cycle: 2 cycles for byte, 3 for word.
REQ-018 Requesters hold req and fields stable until ack and drop req on the edge ending the ack cycle; req still high in IDLE starts a new transfer.
REQ-019 Transfers are atomic; a request arriving mid-transfer waits for IDLE.
REQ-020 Both acks are never high together; ack never fires without a prior grant.
REQ-021 Outside LO/HI, address and out hold their last values and wren=0.

Reset
REQ-022 reset_n low at a rising edge: state=IDLE, wren=0, address=0, out=0, c_ack=d_ack=0, c_rdata=d_rdata=0, last-granted=DMA (CPU wins first tie).
REQ-023 Reset mid-transfer aborts it: no ack is issued, and wren=0 from the next edge.

Configuration
REQ-024 Macro MEMARB_WORD_EN defined: 16-bit transfers are supported per REQ-013..015.
REQ-025 Macro MEMARB_WORD_EN undefined: HI state is absent, c_word/d_word are ignored, all transfers are byte, rdata[15:8]=0, and byte latency is unchanged.

Verification
REQ-026 CPU byte read, c_addr=0x12345, memory 0x12345=0xA5 -> one LO cycle with address=0x12345, wren=0; c_ack 2 cycles after grant; c_rdata=0x00A5.
REQ-027 DMA word write, d_addr=0xFFFFF, d_wdata=0xBEEF -> LO: address 0xFFFFF, out 0xEF, wren=1; HI: address 0x00000, out 0xBE, wren=1; d_ack 3 cycles after grant.
REQ-028 c_req and d_req both held high from reset, byte reads -> grants in order CPU, DMA, CPU, DMA; acks never overlap.
REQ-029 d_req rises during a CPU word transfer -> CPU transfer completes unbroken; DMA is granted at the next IDLE.
REQ-030 reset_n pulsed low during HI of a word write -> wren=0 from the next edge; no ack; outputs at reset values; next request is served normally.
REQ-031 Build without MEMARB_WORD_EN, CPU read with c_word=1 at 0x00010 (memory 0x77) -> single byte cycle; c_rdata=0x0077; ack 2 cycles after grant.
